// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the fetch-to-decode queue: NOP encoding, default sizes
// and field positions inside the packed {npc, instr, pc} entry word.
package if_fetch_queue_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int unsigned IFQ_DEPTH = 4;
    localparam int unsigned IFQ_XLEN  = 32;

    // Field slots within an entry; slot k occupies bits [k*XLEN +: XLEN].
    localparam int unsigned ENT_PC_IDX    = 0;
    localparam int unsigned ENT_INSTR_IDX = 1;
    localparam int unsigned ENT_NPC_IDX   = 2;
    localparam int unsigned ENT_FIELDS    = 3;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Fetch/decode handshake bundle around the fetch queue.
// master = fetch/decode side, slave = the queue itself.
interface if_fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_npc;
    logic            if_ready;
    logic            if_stall;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic [XLEN-1:0] id_npc;
    logic            id_ready;
    logic            flush;
    logic [CW-1:0]   count;

    modport master (
        output if_valid, if_pc, if_instr, if_npc, id_ready, flush,
        input  if_ready, if_stall, id_valid, id_pc, id_instr, id_npc, count
    );

    modport slave (
        input  if_valid, if_pc, if_instr, if_npc, id_ready, flush,
        output if_ready, if_stall, id_valid, id_pc, id_instr, id_npc, count
    );

endinterface

// File: rtl/if_fetch_queue_mem.sv
// Entry storage for the fetch queue: one synchronous write port, one
// asynchronous read port, contents deliberately not reset.
module fq_mem #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 96
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupling FIFO between fetch and decode with single-cycle redirect flush.
// Optional zero-latency empty-queue bypass enabled by defining IFQ_BYPASS_EN.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = IFQ_DEPTH,
    parameter int unsigned XLEN  = IFQ_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_queue_if.slave fq
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = ENT_FIELDS * XLEN;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          empty_c, full_c, bypass_c;
    logic          push_c, pop_c, wr_en_c;
    logic [EW-1:0] wr_entry_c, rd_entry_c;

    // Handshake qualification and next pointer/occupancy state.
    always_comb begin
        empty_c  = (count_q == '0);
        full_c   = (count_q == CW'(DEPTH));
`ifdef IFQ_BYPASS_EN
        bypass_c = empty_c & fq.if_valid & ~fq.flush;
`else
        bypass_c = 1'b0;
`endif
        push_c   = fq.if_valid & ~full_c & ~fq.flush;
        pop_c    = ~empty_c & fq.id_ready & ~fq.flush;
        // A bypassed triple taken by decode the same cycle is never stored.
        wr_en_c  = push_c & ~(bypass_c & fq.id_ready);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(wr_en_c) - CW'(pop_c);
        if (wr_en_c) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_c)   rd_ptr_d = rd_ptr_q + PW'(1);
        if (fq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_entry_c = {fq.if_npc, fq.if_instr, fq.if_pc};

    fq_mem #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en_c),
        .waddr (wr_ptr_q),
        .wdata (wr_entry_c),
        .raddr (rd_ptr_q),
        .rdata (rd_entry_c)
    );

    // Head presentation: bypass, stored head, or an idle NOP bubble.
    always_comb begin
        fq.id_valid = 1'b0;
        fq.id_pc    = '0;
        fq.id_instr = XLEN'(NOP_INSTR);
        fq.id_npc   = '0;
        if (bypass_c) begin
            fq.id_valid = 1'b1;
            fq.id_pc    = fq.if_pc;
            fq.id_instr = fq.if_instr;
            fq.id_npc   = fq.if_npc;
        end else if (!empty_c) begin
            fq.id_valid = 1'b1;
            fq.id_pc    = rd_entry_c[ENT_PC_IDX*XLEN    +: XLEN];
            fq.id_instr = rd_entry_c[ENT_INSTR_IDX*XLEN +: XLEN];
            fq.id_npc   = rd_entry_c[ENT_NPC_IDX*XLEN   +: XLEN];
        end
    end

    assign fq.if_ready = ~full_c;
    assign fq.if_stall = full_c;
    assign fq.count    = count_q;

`ifndef SYNTHESIS
    count_in_range: assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed plus random check of if_fetch_queue against a queue-based model.
module tb_if_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] npc;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    ent_t model_q[$];

    always #5 clk = ~clk;

    if_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) fq_if ();

    if_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .fq  (fq_if.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'h5A5A_0000;
        e.npc   = pc + 32'd4;
        return e;
    endfunction

    // Compare every output against the model for the currently driven inputs.
    task automatic check_all(input string tag, input ent_t in_e, input logic v, input logic fl);
        int          sz;
        logic        byp;
        logic        ev;
        logic [31:0] epc, eins, enpc;
        sz   = model_q.size();
        byp  = BYP && sz == 0 && v && !fl;
        ev   = 1'b0; epc = 32'd0; eins = NOP; enpc = 32'd0;
        if (byp) begin
            ev = 1'b1; epc = in_e.pc; eins = in_e.instr; enpc = in_e.npc;
        end else if (sz != 0) begin
            ev = 1'b1; epc = model_q[0].pc; eins = model_q[0].instr; enpc = model_q[0].npc;
        end
        chk({tag, ".count"},    32'(fq_if.count),    32'(sz));
        chk({tag, ".if_ready"}, 32'(fq_if.if_ready), 32'(sz != DEPTH));
        chk({tag, ".if_stall"}, 32'(fq_if.if_stall), 32'(sz == DEPTH));
        chk({tag, ".id_valid"}, 32'(fq_if.id_valid), 32'(ev));
        chk({tag, ".id_pc"},    fq_if.id_pc,         epc);
        chk({tag, ".id_instr"}, fq_if.id_instr,      eins);
        chk({tag, ".id_npc"},   fq_if.id_npc,        enpc);
    endtask

    // One cycle: drive at the falling edge, check, clock, then update the model.
    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic rdy, input logic fl);
        ent_t e;
        int   sz;
        logic byp;
        e  = mk(pc);
        fq_if.if_valid = v;
        fq_if.if_pc    = e.pc;
        fq_if.if_instr = e.instr;
        fq_if.if_npc   = e.npc;
        fq_if.id_ready = rdy;
        fq_if.flush    = fl;
        #1;
        check_all(tag, e, v, fl);
        sz  = model_q.size();
        byp = BYP && sz == 0 && v && !fl;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else if (!(byp && rdy)) begin
            if (sz != 0 && rdy) void'(model_q.pop_front());
            if (v && sz != DEPTH) model_q.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        fq_if.if_valid = 1'b0;
        fq_if.if_pc    = '0;
        fq_if.if_instr = '0;
        fq_if.if_npc   = '0;
        fq_if.id_ready = 1'b0;
        fq_if.flush    = 1'b0;

        #2;
        chk("reset.count",    32'(fq_if.count),    32'd0);
        chk("reset.id_valid", 32'(fq_if.id_valid), 32'd0);
        chk("reset.id_instr", fq_if.id_instr,      NOP);
        chk("reset.if_ready", 32'(fq_if.if_ready), 32'd1);
        chk("reset.if_stall", 32'(fq_if.if_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Fill to full with decode stalled; a fifth push is dropped.
        for (int k = 0; k < 4; k++) step("fill", 1'b1, 32'(4 * k), 1'b0, 1'b0);
        chk("full.count", 32'(fq_if.count),    32'd4);
        chk("full.stall", 32'(fq_if.if_stall), 32'd1);
        step("fifth", 1'b1, 32'h10, 1'b0, 1'b0);
        chk("full.head", fq_if.id_pc, 32'h00);
        for (int k = 0; k < 4; k++) step("drain", 1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain.valid", 32'(fq_if.id_valid), 32'd0);

        // Full plus pop in the same cycle: push rejected, 4 -> 3.
        for (int k = 0; k < 4; k++) step("refill", 1'b1, 32'h40 + 32'(4 * k), 1'b0, 1'b0);
        step("fullpop", 1'b1, 32'h50, 1'b1, 1'b0);
        chk("fullpop.count", 32'(fq_if.count),    32'd3);
        chk("fullpop.ready", 32'(fq_if.if_ready), 32'd1);
        for (int k = 0; k < 3; k++) step("drain2", 1'b0, 32'h0, 1'b1, 1'b0);

        // Wrap-around with steady push+pop at occupancy 1.
        step("wrap0", 1'b1, 32'h100, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) step("wrap", 1'b1, 32'h100 + 32'(4 * k), 1'b1, 1'b0);
        step("wrapend", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush alongside push and pop at count 2, then a redirected push.
        step("fl_a", 1'b1, 32'h300, 1'b0, 1'b0);
        step("fl_b", 1'b1, 32'h304, 1'b0, 1'b0);
        step("flush", 1'b1, 32'h308, 1'b1, 1'b1);
        chk("flush.count", 32'(fq_if.count), 32'd0);
        step("redir", 1'b1, 32'h200, 1'b0, 1'b0);
        chk("redir.head", fq_if.id_pc, 32'h200);
        step("redir_pop", 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset while three entries are queued.
        for (int k = 0; k < 3; k++) step("pre_rst", 1'b1, 32'h500 + 32'(4 * k), 1'b0, 1'b0);
        fq_if.if_valid = 1'b0;
        fq_if.id_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.count",    32'(fq_if.count),    32'd0);
        chk("arst.id_valid", 32'(fq_if.id_valid), 32'd0);
        chk("arst.id_instr", fq_if.id_instr,      NOP);
        #1 rst = 1'b0;
        model_q.delete();
        @(negedge clk);

        // Empty queue with decode ready: bypass or one-cycle latency.
        step("byp", 1'b1, 32'h40, 1'b1, 1'b0);
        step("byp_next", 1'b0, 32'h0, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            logic [31:0] pc;
            pc = $urandom() & 32'hFFFF_FFFC;
            step("rand", 1'($urandom_range(0, 3) != 0), pc,
                 1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
